amax10_fb_scanout_reader: RTL and testbench

- Frame-buffer scan-out engine that reads pixel words from the on-chip RAM's second Avalon slave port and presents them as a valid/ready pixel stream to the HDMI timing/formatter stage feeding the ADV7513.
- On each start request it reads one frame: FB_WORDS sequential 32-bit words from BASE onward, buffered in a small prefetch FIFO. It also marks start-of-frame and end-of-line.

---
 rtl/amax10_fb_scanout_reader_if.sv | 40 ++++
 rtl/amax10_fb_scanout_reader.sv | 158 +++++++++++++++
 tb/tb_amax10_fb_scanout_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/amax10_fb_scanout_reader_if.sv
// Bus bundle for the frame-buffer scan-out reader.
// Groups the RAM read port (Avalon slave side of the on-chip RAM) and the
// outgoing valid/ready pixel stream.
//   master : the scan-out reader (drives RAM requests, sources pixels)
//   slave  : RAM + downstream formatter (returns read data, accepts pixels)
// Ports carried:
//   mem_address/mem_chipselect/mem_write/mem_byteenable/mem_clken -> RAM
//   mem_readdata                                                   <- RAM
//   pix_data/pix_valid/pix_sof/pix_eol -> downstream, pix_ready <- downstream
`timescale 1ns/1ps
interface amax10_fb_scanout_reader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    logic [23:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eol;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output pix_data, pix_valid, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  pix_data, pix_valid, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/amax10_fb_scanout_reader.sv
// Frame-buffer scan-out reader.
// On an accepted start, reads FB_WORDS sequential words from base_addr via the
// RAM port (1-cycle read latency), buffers them in a prefetch FIFO and emits
// them as a valid/ready pixel stream with start-of-frame / end-of-line flags.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle frame request (ignored while busy)
//   base_addr       : first word address, latched on accepted start
//   busy            : frame in progress
//   frame_done      : one-cycle pulse the cycle after the last pixel transfer
//   underrun_count  : starved-cycle counter (only when FB_SCANOUT_UNDERRUN_CNT_EN
//                     is defined; otherwise tied to 0)
//   bus (master)    : RAM read port and pixel stream
// The interface instance must use the same ADDR_W as this module.
`timescale 1ns/1ps
module amax10_fb_scanout_reader #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FB_WORDS   = 40000,
    parameter int unsigned LINE_WORDS = 200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       underrun_count,
    amax10_fb_scanout_reader_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam int unsigned COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB_WORDS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  issue_idx_q;
    logic              inflight_q;
    logic [23:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [COL_W-1:0]  col_q;
    logic              first_q;
    logic              frame_done_q;

    logic accept, issue, push, pop, done;
    logic unused_readdata_hi;

    assign unused_readdata_hi = ^bus.mem_readdata[31:24];

    assign accept = (state_q == StIdle) && start;
    // Issue only while the FIFO is guaranteed to have room for the return.
    assign issue  = (state_q == StRun) && ((fifo_cnt_q + CNT_W'(inflight_q)) < DEPTH);
    assign push   = inflight_q;
    assign pop    = bus.pix_valid && bus.pix_ready;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (issue && (issue_idx_q == LAST_IDX)) state_d = StDrain;
            StDrain: begin
                // Leave on the edge of the final transfer so frame_done and
                // the falling busy appear together in the next cycle.
                if (fifo_cnt_d == '0) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            issue_idx_q  <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            col_q        <= '0;
            first_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= issue;
            frame_done_q <= done;
            fifo_cnt_q   <= fifo_cnt_d;
            if (accept) begin
                addr_q      <= base_addr;
                issue_idx_q <= '0;
                col_q       <= '0;
                first_q     <= 1'b1;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                issue_idx_q <= issue_idx_q + IDX_W'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                first_q  <= 1'b0;
                col_q    <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_readdata[23:0];
        end
    end

`ifdef FB_SCANOUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            underrun_q <= '0;
        end else if (busy && bus.pix_ready && !bus.pix_valid && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end
    assign underrun_count = underrun_q;
`else
    assign underrun_count = '0;
`endif

    assign busy               = (state_q != StIdle);
    assign frame_done         = frame_done_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.pix_valid      = (fifo_cnt_q != '0);
    assign bus.pix_data       = fifo_mem[rd_ptr_q];
    assign bus.pix_sof        = bus.pix_valid && first_q;
    assign bus.pix_eol        = bus.pix_valid && (col_q == LAST_COL);
endmodule

// File: tb/tb_amax10_fb_scanout_reader.sv
`timescale 1ns/1ps
module tb_amax10_fb_scanout_reader;
    localparam int FB = 32;
    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        busy;
    logic        frame_done;
    logic [15:0] underrun_count;
    int          checks = 0;
    int          errors = 0;

    amax10_fb_scanout_reader_if #(.ADDR_W(16)) bus ();

    amax10_fb_scanout_reader #(
        .ADDR_W(16), .FB_WORDS(FB), .LINE_WORDS(LW), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .frame_done(frame_done), .underrun_count(underrun_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM model: word[a] = {A5, 00, a}; junk when not requested.
    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= {8'hA5, 8'h00, bus.mem_address};
        else                    bus.mem_readdata <= $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; lat = check exact full-rate timing; repulse_at/reset_at
    // (>=0) re-pulse start or assert reset when that pixel index is presented.
    task automatic run_frame(input logic [15:0] base, input int stall_pct, input bit lat,
                             input int repulse_at, input int reset_at);
        int k, j, cyc, ndone;
        logic [15:0] a;
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = 16'h5A5A;
        k = 0; j = 0; cyc = 1; ndone = 0;
        while (cyc < 1500 && ndone == 0) begin
            bus.pix_ready = ($urandom_range(99) >= stall_pct);
            if (bus.mem_chipselect) begin
                a = 16'(base + j);
                chk("mem_address", {16'h0, bus.mem_address}, {16'h0, a});
                if (lat) chk("issue_cycle", cyc, 1 + j);
                j++;
            end
            if (bus.pix_valid) begin
                a = 16'(base + k);
                chk("pix_data", {8'h0, bus.pix_data}, {16'h0, a});
                chk("pix_sof", bus.pix_sof, (k == 0));
                chk("pix_eol", bus.pix_eol, ((k % LW) == LW - 1));
                if (lat) chk("pix_cycle", cyc, 3 + k);
            end
            if (frame_done) begin
                ndone++;
                chk("busy_at_done", busy, 0);
                chk("pixel_count", k, FB);
                chk("issue_count", j, FB);
                if (lat) chk("done_cycle", cyc, 3 + FB);
            end else begin
                chk("busy", busy, 1);
            end
            if (reset_at >= 0 && bus.pix_valid && k == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_valid", bus.pix_valid, 0);
                chk("rst_cs", bus.mem_chipselect, 0);
                chk("rst_underrun", underrun_count, 0);
                tick();
                chk("rst_no_done", frame_done, 0);
                return;
            end
            start = (repulse_at >= 0 && k == repulse_at && bus.pix_valid);
            if (bus.pix_valid && bus.pix_ready) k++;
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", ndone, 1);
        chk("done_pulse_low", frame_done, 0);
        chk("busy_after", busy, 0);
        repeat (4) begin
            if (frame_done) ndone++;
            tick();
        end
        chk("done_once", ndone, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        bus.pix_ready = 1'b0;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_cs", bus.mem_chipselect, 0);
        chk("reset_addr", {16'h0, bus.mem_address}, 0);
        chk("reset_valid", bus.pix_valid, 0);
        chk("reset_sof", bus.pix_sof, 0);
        chk("reset_eol", bus.pix_eol, 0);
        chk("reset_underrun", underrun_count, 0);
        chk("mem_write", bus.mem_write, 0);
        chk("mem_byteenable", {28'h0, bus.mem_byteenable}, 32'hF);
        chk("mem_clken", bus.mem_clken, 1);
        reset = 1'b0;
        tick();

        // Full rate from base 0 with exact latency checks.
        run_frame(16'h0000, 0, 1'b1, -1, -1);
`ifdef FB_SCANOUT_UNDERRUN_CNT_EN
        chk("underrun", underrun_count, 2);
`else
        chk("underrun", underrun_count, 0);
`endif
        // Random backpressure (30% stall).
        run_frame(16'h0100, 30, 1'b0, -1, -1);
        // Address wrap past FFFF.
        run_frame(16'hFFF0, 0, 1'b0, -1, -1);
        // Start re-pulsed mid-frame is ignored.
        run_frame(16'h0040, 0, 1'b0, 5, -1);
        // Reset mid-frame, then a fresh frame from a new base.
        run_frame(16'h3000, 0, 1'b0, -1, 10);
        run_frame(16'h2000, 30, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
